// File: rtl/safeguard_pkg.sv
// Shared state and key codes for the parking safeguard pass-key controller
// and the LCD message stage that consumes its state code.
package safeguard_pkg;

  typedef enum logic [2:0] {
    SG_ARMED  = 3'd0,
    SG_LOCKED = 3'd1,
    SG_OPEN   = 3'd2
  } sg_state_e;

  localparam logic [3:0] KEY_CLEAR    = 4'hA;
  localparam logic [3:0] KEY_ENTER    = 4'hB;
  localparam logic [2:0] ENTRY_DIGITS = 3'd4;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/safeguard_timer.sv
// Loadable 32-bit down counter used for the lockout and open timeouts.
// It stops at zero and only moves again on a fresh load.
module safeguard_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] value,
  output logic        zero
);

  logic [31:0] count_r;

  // Count register: load wins, otherwise decrement toward zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != 32'd0) begin
      count_r <= count_r - 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign value = count_r;
  assign zero  = (count_r == 32'd0);

endmodule

// File: rtl/safeguard_ctrl.sv
// Pass-key controller: collects keypad digits, checks a 4-digit entry against
// PASS_KEY and sequences ARMED / LOCKED / OPEN for the LCD message stage.
module safeguard_ctrl
  import safeguard_pkg::*;
#(
  parameter logic [15:0] PASS_KEY    = 16'h1234,
  parameter logic [31:0] LOCK_CYCLES = 32'd100_000_000,
  parameter logic [31:0] OPEN_CYCLES = 32'd500_000_000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iKEY_VALID,
  input  logic [3:0] iKEY_CODE,
  input  logic       iCLOSE,
  output logic [2:0] SafeGuard_State,
  output logic [2:0] oDIGIT_CNT,
  output logic [3:0] oFAIL_CNT
);

  sg_state_e   state_r, state_next_s;
  logic [15:0] entry_r;
  logic [2:0]  digit_cnt_r;
  logic [3:0]  fail_cnt_r;

  logic        timer_load_s;
  logic [31:0] timer_load_value_s;
  logic [31:0] timer_value_s;
  logic        timer_zero_s;
  logic        timer_done_s;
  logic        enter_s;
  logic        key_match_s;
  logic        digit_shift_s;
  logic        entry_clear_s;
  logic        fail_inc_s;

  safeguard_timer u_timer (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .load       (timer_load_s),
    .load_value (timer_load_value_s),
    .value      (timer_value_s),
    .zero       (timer_zero_s)
  );

  // The timer reaches zero on this edge, so a state of N cycles ends exactly at N.
  assign timer_done_s = timer_zero_s || (timer_value_s == 32'd1);
  assign enter_s      = iKEY_VALID && (iKEY_CODE == KEY_ENTER);
  assign key_match_s  = (digit_cnt_r == ENTRY_DIGITS) && (entry_r == PASS_KEY);

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= SG_ARMED;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SG_ARMED: begin
        if (enter_s) begin
          state_next_s = key_match_s ? SG_OPEN : SG_LOCKED;
        end else begin
          state_next_s = SG_ARMED;
        end
      end
      SG_LOCKED: begin
        if (timer_done_s) state_next_s = SG_ARMED;
        else              state_next_s = SG_LOCKED;
      end
      SG_OPEN: begin
        if (iCLOSE || timer_done_s) state_next_s = SG_ARMED;
        else                        state_next_s = SG_OPEN;
      end
      default: state_next_s = SG_ARMED;
    endcase
  end

  // Control decode: entry buffer, fail counter and timer actions per state.
  always_comb begin
    timer_load_s       = 1'b0;
    timer_load_value_s = 32'd0;
    digit_shift_s      = 1'b0;
    entry_clear_s      = 1'b0;
    fail_inc_s         = 1'b0;
    case (state_r)
      SG_ARMED: begin
        if (iKEY_VALID && is_digit(iKEY_CODE)) begin
          digit_shift_s = (digit_cnt_r < ENTRY_DIGITS);
        end else if (iKEY_VALID && (iKEY_CODE == KEY_CLEAR)) begin
          entry_clear_s = 1'b1;
        end else if (enter_s) begin
          entry_clear_s = 1'b1;
          timer_load_s  = 1'b1;
          if (key_match_s) begin
            timer_load_value_s = OPEN_CYCLES;
          end else begin
            timer_load_value_s = LOCK_CYCLES;
            fail_inc_s         = 1'b1;
          end
        end else begin
          digit_shift_s = 1'b0;
        end
      end
      SG_LOCKED: begin
        timer_load_s = timer_done_s;
      end
      SG_OPEN: begin
        // Clearing on exit keeps the timer at zero while armed after an early close.
        timer_load_s = iCLOSE || timer_done_s;
      end
      default: begin
        timer_load_s = 1'b1;
      end
    endcase
  end

  // Entry buffer, digit count and saturating fail counter.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      entry_r     <= 16'd0;
      digit_cnt_r <= 3'd0;
      fail_cnt_r  <= 4'd0;
    end else begin
      if (entry_clear_s) begin
        entry_r     <= 16'd0;
        digit_cnt_r <= 3'd0;
      end else if (digit_shift_s) begin
        entry_r     <= {entry_r[11:0], iKEY_CODE};
        digit_cnt_r <= digit_cnt_r + 3'd1;
      end else begin
        entry_r     <= entry_r;
        digit_cnt_r <= digit_cnt_r;
      end
      if (fail_inc_s && (fail_cnt_r != 4'hF)) begin
        fail_cnt_r <= fail_cnt_r + 4'd1;
      end else begin
        fail_cnt_r <= fail_cnt_r;
      end
    end
  end

  assign SafeGuard_State = state_r;
  assign oDIGIT_CNT      = digit_cnt_r;
  assign oFAIL_CNT       = fail_cnt_r;

endmodule

// File: tb/tb_safeguard_ctrl.sv
// Self-checking bench for safeguard_ctrl: a vector table, directed multi-cycle
// sequences and random traffic, all compared against a cycle-level key model.
module tb_safeguard_ctrl;
  import safeguard_pkg::*;

  localparam int LOCK_N  = 8;
  localparam int OPEN_N  = 16;
  localparam int KEY_VAL = 'h1234;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       close_req;
  logic [2:0] sg_state;
  logic [2:0] digit_cnt;
  logic [3:0] fail_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  safeguard_ctrl #(
    .PASS_KEY    (16'h1234),
    .LOCK_CYCLES (32'd8),
    .OPEN_CYCLES (32'd16)
  ) dut (
    .iCLK            (clk),
    .iRST_N          (rst_n),
    .iKEY_VALID      (key_valid),
    .iKEY_CODE       (key_code),
    .iCLOSE          (close_req),
    .SafeGuard_State (sg_state),
    .oDIGIT_CNT      (digit_cnt),
    .oFAIL_CNT       (fail_cnt)
  );

  // Reference model: mode 0/1/2, remaining cycles, digit queue, fail count.
  int m_mode;
  int m_remain;
  int m_fail;
  int m_digits[$];

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       cl;
    int         st;
    int         cnt;
    int         fl;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_remain = 0; m_fail = 0;
    m_digits.delete();
  endtask

  task automatic model_edge(input logic v, input logic [3:0] c, input logic cl);
    int val;
    case (m_mode)
      0: if (v) begin
        if (c <= 4'd9) begin
          if (m_digits.size() < 4) m_digits.push_back(int'(c));
        end else if (c == 4'hA) begin
          m_digits.delete();
        end else if (c == 4'hB) begin
          val = 0;
          foreach (m_digits[i]) val = val * 16 + m_digits[i];
          if (m_digits.size() == 4 && val == KEY_VAL) begin
            m_mode = 2; m_remain = OPEN_N;
          end else begin
            m_mode = 1; m_remain = LOCK_N;
            if (m_fail < 15) m_fail++;
          end
          m_digits.delete();
        end
      end
      1: begin
        m_remain--;
        if (m_remain == 0) m_mode = 0;
      end
      default: begin
        m_remain--;
        if (cl || m_remain == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic cl);
    @(negedge clk);
    key_valid = v; key_code = c; close_req = cl;
    @(posedge clk);
    model_edge(v, c, cl);
    #1;
    check("state", int'(sg_state), m_mode);
    check("digit_cnt", int'(digit_cnt), m_digits.size());
    check("fail_cnt", int'(fail_cnt), m_fail);
    key_valid = 1'b0; key_code = 4'd0; close_req = 1'b0;
  endtask

  task automatic wait_armed(input string name);
    int budget;
    budget = 40;
    while (sg_state != 3'd0 && budget > 0) begin
      budget--;
      step(1'b0, 4'd0, 1'b0);
    end
    check(name, int'(sg_state), 0);
  endtask

  initial begin
    int run;
    int budget;
    logic       v;
    logic [3:0] c;
    logic       cl;
    int r;

    vecs[0]  = '{1'b1, 4'd1, 1'b0, 0, 1, 0};
    vecs[1]  = '{1'b1, 4'd2, 1'b0, 0, 2, 0};
    vecs[2]  = '{1'b1, 4'd3, 1'b0, 0, 3, 0};
    vecs[3]  = '{1'b1, 4'd4, 1'b0, 0, 4, 0};
    vecs[4]  = '{1'b1, 4'd9, 1'b0, 0, 4, 0};
    vecs[5]  = '{1'b1, 4'hB, 1'b0, 2, 0, 0};
    vecs[6]  = '{1'b1, 4'd5, 1'b0, 2, 0, 0};
    vecs[7]  = '{1'b0, 4'd0, 1'b0, 2, 0, 0};
    vecs[8]  = '{1'b0, 4'd0, 1'b1, 0, 0, 0};
    vecs[9]  = '{1'b1, 4'd7, 1'b0, 0, 1, 0};
    vecs[10] = '{1'b1, 4'hA, 1'b0, 0, 0, 0};
    vecs[11] = '{1'b1, 4'hC, 1'b0, 0, 0, 0};
    vecs[12] = '{1'b1, 4'd1, 1'b0, 0, 1, 0};
    vecs[13] = '{1'b1, 4'd2, 1'b0, 0, 2, 0};
    vecs[14] = '{1'b1, 4'hB, 1'b0, 1, 0, 1};
    vecs[15] = '{1'b1, 4'd3, 1'b0, 1, 0, 1};
    vecs[16] = '{1'b0, 4'd0, 1'b1, 1, 0, 1};

    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; close_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'(sg_state), 0);
    check("reset_digit_cnt", int'(digit_cnt), 0);
    check("reset_fail_cnt", int'(fail_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].v, vecs[i].c, vecs[i].cl);
      check($sformatf("vec%0d_state", i), int'(sg_state), vecs[i].st);
      check($sformatf("vec%0d_cnt", i), int'(digit_cnt), vecs[i].cnt);
      check($sformatf("vec%0d_fail", i), int'(fail_cnt), vecs[i].fl);
    end
    wait_armed("rearm_after_short");

    // Wrong key: LOCKED for exactly 8 samples; digits sent meanwhile are ignored.
    step(1'b1, 4'd1, 1'b0); step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0); step(1'b1, 4'd5, 1'b0);
    step(1'b1, KEY_ENTER, 1'b0);
    run = 0; budget = 40;
    while (sg_state == 3'd1 && budget > 0) begin
      run++; budget--;
      step(1'b1, 4'd6, 1'b0);
    end
    check("lock_len", run, LOCK_N);
    check("key_dropped_on_rearm", int'(digit_cnt), 0);
    check("fail_after_wrong", int'(fail_cnt), 2);
    step(1'b1, 4'd6, 1'b0);
    check("first_key_after_rearm", int'(digit_cnt), 1);
    step(1'b1, KEY_CLEAR, 1'b0);

    // Correct key with no close: OPEN for exactly 16 samples.
    step(1'b1, 4'd1, 1'b0); step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0); step(1'b1, 4'd4, 1'b0);
    step(1'b1, KEY_ENTER, 1'b0);
    run = 0; budget = 40;
    while (sg_state == 3'd2 && budget > 0) begin
      run++; budget--;
      step(1'b1, 4'd1, 1'b0);
    end
    check("open_len", run, OPEN_N);
    check("open_fail_unchanged", int'(fail_cnt), 2);

    // Saturation of the fail counter.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, KEY_ENTER, 1'b0);
      wait_armed("rearm_sat");
    end
    check("fail_saturated", int'(fail_cnt), 15);

    // Asynchronous reset mid-LOCKED, checked before any further clock edge.
    step(1'b1, 4'd2, 1'b0);
    step(1'b1, KEY_ENTER, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(sg_state), 0);
    check("async_rst_fail", int'(fail_cnt), 0);
    check("async_rst_cnt", int'(digit_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, biased toward the correct key so OPEN is reached often.
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(9, 0) < 7);
      cl = ($urandom_range(7, 0) == 0);
      r  = $urandom_range(9, 0);
      if (r < 5) c = (m_digits.size() < 4) ? 4'(m_digits.size() + 1) : KEY_ENTER;
      else if (r < 7) c = KEY_ENTER;
      else if (r == 7) c = KEY_CLEAR;
      else c = 4'($urandom_range(15, 0));
      step(v, c, cl);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
